add_sub_vector_checker: RTL and testbench

//  Self-checking harness for the 4-bit adder/subtractor lab DUTs, built in hardware.
//  - Accepts operand vectors over a valid/ready stream.
//  - Drives each vector to an external adder/subtractor and waits a settle window.
//  - Samples the DUT result and compares it against an internal golden model.
//  - Reports pass/fail, vector and error counts, and the index of the first mismatch.

---
 rtl/add_sub_pkg.sv | 15 +
 rtl/add_sub_ref_model.sv | 22 ++
 rtl/add_sub_vector_checker.sv | 125 ++++++++++++
 tb/tb_add_sub_vector_checker.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/add_sub_pkg.sv
// Shared definitions for the 4-bit adder/subtractor lab: the default operand width
// and the checker FSM state encoding that the lab benches also decode.
package add_sub_pkg;

    localparam int WIDTH_DEF = 4;

    typedef logic [2:0] state_t;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WAIT   = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_CHECK  = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

endpackage

// File: rtl/add_sub_ref_model.sv
// Golden adder/subtractor: subtraction is A + ~B + 1, so cout=1 means "no borrow".
module add_sub_ref_model
    import add_sub_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;

    assign b_eff = sel ? ~b : b;
    assign sum   = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sel};
    assign s     = sum[WIDTH-1:0];
    assign cout  = sum[WIDTH];

endmodule

// File: rtl/add_sub_vector_checker.sv
// Hardware self-check harness: takes one vector at a time, drives it to an external
// adder/subtractor, waits SETTLE cycles, then scores the DUT against the golden model.
module add_sub_vector_checker
    import add_sub_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int CNT_W  = 8,
    parameter int SETTLE = 3          // legal range 1..15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             vec_valid,
    output logic             vec_ready,
    input  logic [WIDTH-1:0] vec_a,
    input  logic [WIDTH-1:0] vec_b,
    input  logic             vec_sel,
    input  logic             vec_last,
    output logic [WIDTH-1:0] dut_a,
    output logic [WIDTH-1:0] dut_b,
    output logic             dut_sel,
    input  logic [WIDTH-1:0] dut_s,
    input  logic             dut_cout,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             fail_valid,
    output logic [CNT_W-1:0] fail_idx,
    output logic [2:0]       fsm_state
);

    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE - 1);

    // Handshake: a vector transfers on a rising edge where vec_valid && vec_ready;
    // vec_ready is high only in WAIT, so at most one vector is ever in flight.

    state_t           state;
    logic [3:0]       settle_cnt;
    logic             last_q;
    logic [WIDTH-1:0] ref_s;
    logic             ref_cout;
    logic             mismatch;

    add_sub_ref_model #(.WIDTH(WIDTH)) u_ref (
        .a    (dut_a),
        .b    (dut_b),
        .sel  (dut_sel),
        .s    (ref_s),
        .cout (ref_cout)
    );

    assign mismatch = (dut_s != ref_s) || (dut_cout != ref_cout);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            settle_cnt <= '0;
            last_q     <= 1'b0;
            dut_a      <= '0;
            dut_b      <= '0;
            dut_sel    <= 1'b0;
            vec_cnt    <= '0;
            err_cnt    <= '0;
            fail_valid <= 1'b0;
            fail_idx   <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        vec_cnt    <= '0;
                        err_cnt    <= '0;
                        fail_valid <= 1'b0;
                        fail_idx   <= '0;
                        state      <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (vec_valid) begin
                        dut_a      <= vec_a;
                        dut_b      <= vec_b;
                        dut_sel    <= vec_sel;
                        last_q     <= vec_last;
                        settle_cnt <= '0;
                        state      <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= ST_CHECK;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                ST_CHECK: begin
                    // Counters stick at all-ones; fail_idx captures the saturated value too.
                    if (mismatch) begin
                        if (err_cnt != CNT_MAX) begin
                            err_cnt <= err_cnt + CNT_ONE;
                        end
                        if (!fail_valid) begin
                            fail_valid <= 1'b1;
                            fail_idx   <= vec_cnt;
                        end
                    end
                    if (vec_cnt != CNT_MAX) begin
                        vec_cnt <= vec_cnt + CNT_ONE;
                    end
                    state <= last_q ? ST_DONE : ST_WAIT;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign vec_ready = (state == ST_WAIT);
    assign busy      = (state == ST_WAIT) || (state == ST_SETTLE) || (state == ST_CHECK);
    assign done      = (state == ST_DONE);
    assign pass      = done && (err_cnt == '0);
    assign fsm_state = state;

endmodule

// File: tb/tb_add_sub_vector_checker.sv
// Directed and randomized bench for add_sub_vector_checker: a behavioural lab DUT
// (optionally faulty or slow) plus a vector-level model of the expected scores.
module tb_add_sub_vector_checker;
    import add_sub_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [1:0]      start, vec_valid, vec_sel, vec_last;
    logic [1:0][3:0] vec_a, vec_b;
    wire  [1:0]      vec_ready, dut_sel, dut_cout, busy, done, pass, fail_valid;
    wire  [1:0][3:0] dut_a, dut_b, dut_s;
    wire  [1:0][2:0] fsm_state;
    wire  [7:0]      vec_cnt0, err_cnt0, fail_idx0;
    wire  [1:0]      vec_cnt1, err_cnt1, fail_idx1;

    // Lab DUT stand-in: fault mask flips result bits, delay_en adds a 2-cycle output lag.
    logic [1:0][4:0] fault_m;
    logic [1:0]      delay_en;
    logic [1:0][4:0] p1, p2;

    int checks = 0;
    int errors = 0;
    int m_n[2], m_bad[2], m_first[2];
    logic [8:0] exp_q[$];

    function automatic logic [4:0] golden(input logic [3:0] a, input logic [3:0] b, input logic sel);
        int d;
        if (sel) begin
            d = int'(a) - int'(b);
            return {(a >= b), 4'(d)};
        end
        d = int'(a) + int'(b);
        return {(d > 15), 4'(d)};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_lab
        assign {dut_cout[g], dut_s[g]} = delay_en[g] ? p2[g]
                                       : (golden(dut_a[g], dut_b[g], dut_sel[g]) ^ fault_m[g]);
    end

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            p1[k] <= golden(dut_a[k], dut_b[k], dut_sel[k]) ^ fault_m[k];
            p2[k] <= p1[k];
        end
    end

    add_sub_vector_checker u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]),
        .vec_valid(vec_valid[0]), .vec_ready(vec_ready[0]),
        .vec_a(vec_a[0]), .vec_b(vec_b[0]), .vec_sel(vec_sel[0]), .vec_last(vec_last[0]),
        .dut_a(dut_a[0]), .dut_b(dut_b[0]), .dut_sel(dut_sel[0]),
        .dut_s(dut_s[0]), .dut_cout(dut_cout[0]),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]),
        .vec_cnt(vec_cnt0), .err_cnt(err_cnt0),
        .fail_valid(fail_valid[0]), .fail_idx(fail_idx0), .fsm_state(fsm_state[0])
    );

    add_sub_vector_checker #(.CNT_W(2), .SETTLE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]),
        .vec_valid(vec_valid[1]), .vec_ready(vec_ready[1]),
        .vec_a(vec_a[1]), .vec_b(vec_b[1]), .vec_sel(vec_sel[1]), .vec_last(vec_last[1]),
        .dut_a(dut_a[1]), .dut_b(dut_b[1]), .dut_sel(dut_sel[1]),
        .dut_s(dut_s[1]), .dut_cout(dut_cout[1]),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]),
        .vec_cnt(vec_cnt1), .err_cnt(err_cnt1),
        .fail_valid(fail_valid[1]), .fail_idx(fail_idx1), .fsm_state(fsm_state[1])
    );

    function automatic int cnt_max(input int k);
        return (k == 0) ? 255 : 3;
    endfunction
    function automatic int settle_of(input int k);
        return (k == 0) ? 3 : 1;
    endfunction
    function automatic int sat(input int v, input int m);
        return (v > m) ? m : v;
    endfunction
    function automatic int rd_vec(input int k);
        return (k == 0) ? int'(vec_cnt0) : int'(vec_cnt1);
    endfunction
    function automatic int rd_err(input int k);
        return (k == 0) ? int'(err_cnt0) : int'(err_cnt1);
    endfunction
    function automatic int rd_fidx(input int k);
        return (k == 0) ? int'(fail_idx0) : int'(fail_idx1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear(input int k);
        m_n[k]     = 0;
        m_bad[k]   = 0;
        m_first[k] = -1;
    endtask

    task automatic start_run(input int k);
        start[k] = 1'b1;
        tick();
        start[k] = 1'b0;
        model_clear(k);
        check("start_ready", vec_ready[k], 1);
        check("start_vec_cnt", rd_vec(k), 0);
        check("start_fail_valid", fail_valid[k], 0);
    endtask

    task automatic handshake(input int k, input logic [3:0] a, input logic [3:0] b,
                             input logic sel, input logic last, input logic [4:0] mask,
                             input logic bad);
        int w = 0;
        fault_m[k]   = mask;
        vec_a[k]     = a;
        vec_b[k]     = b;
        vec_sel[k]   = sel;
        vec_last[k]  = last;
        vec_valid[k] = 1'b1;
        while (!vec_ready[k] && w < 50) begin
            tick();
            w++;
        end
        check("ready_timeout", (w < 50), 1);
        exp_q.push_back({sel, a, b});
        tick();
        vec_valid[k] = 1'b0;
        check("dut_operands", {dut_sel[k], dut_a[k], dut_b[k]}, exp_q.pop_front());
        check("busy_in_flight", busy[k], 1);
        check("ready_low_in_flight", vec_ready[k], 0);
        if (bad && m_first[k] < 0) m_first[k] = m_n[k];
        m_n[k]++;
        if (bad) m_bad[k]++;
    endtask

    task automatic wait_result(input int k, input logic poke);
        int lat = 0;
        do begin
            if (poke && lat == 0) start[k] = 1'b1;
            tick();
            start[k] = 1'b0;
            lat++;
        end while (!(vec_ready[k] || done[k]) && lat < 60);
        check("latency", lat, settle_of(k) + 1);
    endtask

    task automatic check_done(input int k);
        int mx = cnt_max(k);
        check("done", done[k], 1);
        check("busy_at_done", busy[k], 0);
        check("vec_cnt", rd_vec(k), sat(m_n[k], mx));
        check("err_cnt", rd_err(k), sat(m_bad[k], mx));
        check("fail_valid", fail_valid[k], (m_first[k] >= 0));
        check("fail_idx", rd_fidx(k), (m_first[k] >= 0) ? sat(m_first[k], mx) : 0);
        check("pass", pass[k], (m_bad[k] == 0));
    endtask

    task automatic send(input int k, input logic [3:0] a, input logic [3:0] b, input logic sel,
                        input logic last, input logic [4:0] mask, input logic bad, input logic poke);
        handshake(k, a, b, sel, last, mask, bad);
        wait_result(k, poke);
        if (last) check_done(k);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] m;
        int n;
        start = '0; vec_valid = '0; vec_sel = '0; vec_last = '0;
        vec_a = '0; vec_b = '0; fault_m = '0; delay_en = '0;
        model_clear(0);
        model_clear(1);

        // Reset state
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #20;
        for (int k = 0; k < 2; k++) begin
            check("rst_ready", vec_ready[k], 0);
            check("rst_busy", busy[k], 0);
            check("rst_done", done[k], 0);
            check("rst_pass", pass[k], 0);
            check("rst_vec_cnt", rd_vec(k), 0);
            check("rst_fail_valid", fail_valid[k], 0);
            check("rst_dut_a", dut_a[k], 0);
        end
        @(negedge clk) rst_n = 1'b1;
        tick();
        check("idle_ready", vec_ready[0], 0);

        // Single subtract, then two adds with the last one closing the run
        start_run(0);
        send(0, 4'b1101, 4'b1111, 1'b1, 1'b1, 5'h00, 1'b0, 1'b0);
        start_run(0);
        send(0, 4'b1101, 4'b1111, 1'b0, 1'b0, 5'h00, 1'b0, 1'b0);
        send(0, 4'b0100, 4'b0111, 1'b0, 1'b1, 5'h00, 1'b0, 1'b0);

        // Faulty result on vector index 2 of 4
        start_run(0);
        send(0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0, 1'b0, 5'h00, 1'b0, 1'b0);
        send(0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b1, 1'b0, 5'h00, 1'b0, 1'b0);
        send(0, 4'b0011, 4'b1100, 1'b1, 1'b0, 5'h01, 1'b1, 1'b0);
        send(0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0, 1'b1, 5'h00, 1'b0, 1'b0);

        // Slow DUT: long settle window samples correctly, one-cycle window does not
        delay_en[0] = 1'b1;
        start_run(0);
        send(0, 4'b1000, 4'b0101, 1'b1, 1'b1, 5'h00, 1'b0, 1'b0);
        delay_en[0] = 1'b0;
        delay_en[1] = 1'b1;
        start_run(1);
        send(1, 4'b1000, 4'b0101, 1'b1, 1'b1, 5'h00, 1'b1, 1'b0);
        delay_en[1] = 1'b0;

        // Randomized runs with occasional corrupted results
        for (int r = 0; r < 3; r++) begin
            n = $urandom_range(3, 8);
            start_run(0);
            for (int i = 0; i < n; i++) begin
                m = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'h00;
                send(0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                     1'($urandom_range(0, 1)), (i == n - 1), m, (m != 5'h00), 1'b0);
            end
        end

        // Asynchronous reset mid-SETTLE
        start_run(0);
        handshake(0, 4'b0110, 4'b0010, 1'b0, 1'b0, 5'h00, 1'b0);
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", busy[0], 0);
        check("midrst_state", fsm_state[0], ST_IDLE);
        check("midrst_dut_a", dut_a[0], 0);
        check("midrst_dut_b", dut_b[0], 0);
        check("midrst_vec_cnt", rd_vec(0), 0);
        check("midrst_done1", done[1], 0);
        model_clear(0);
        model_clear(1);
        @(negedge clk) rst_n = 1'b1;
        vec_valid[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("no_ready_before_start", vec_ready[0], 0);
        end
        start_run(0);
        send(0, 4'b1111, 4'b0001, 1'b0, 1'b1, 5'h00, 1'b0, 1'b0);

        // Saturating counters on CNT_W=2, start pulsed during SETTLE is ignored
        start_run(1);
        for (int i = 0; i < 5; i++) begin
            send(1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), (i == 4), 5'($urandom_range(1, 31)), 1'b1, (i == 1));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
